// File: rtl/wb_stage_if.sv
// Bus between the EX/WB buffer, the writeback stage and its consumers
// (register file, PC, upstream flush, debug counter).
interface wb_stage_if #(
    parameter int DATA_W = 33,
    parameter int REG_AW = 6
);
    logic              in_ctrl_regwrt;
    logic              in_ctrl_branch;
    logic              in_ctrl_btype;
    logic              in_ctrl_jump;
    logic              in_ctrl_memtoreg;
    logic              in_ctrl_neg;
    logic              in_ctrl_zero;
    logic [DATA_W-1:0] in_memdata;
    logic [DATA_W-1:0] in_aluresult;
    logic [REG_AW-1:0] in_rd;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              pc_redirect;
    logic [DATA_W-1:0] pc_target;
    logic              flush;
    logic [31:0]       retired;

    // Writeback stage side
    modport slave (
        input  in_ctrl_regwrt, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump,
               in_ctrl_memtoreg, in_ctrl_neg, in_ctrl_zero,
               in_memdata, in_aluresult, in_rd,
        output rf_we, rf_waddr, rf_wdata, pc_redirect, pc_target, flush, retired
    );

    // Driver side (EX/WB buffer plus downstream observers)
    modport master (
        output in_ctrl_regwrt, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump,
               in_ctrl_memtoreg, in_ctrl_neg, in_ctrl_zero,
               in_memdata, in_aluresult, in_rd,
        input  rf_we, rf_waddr, rf_wdata, pc_redirect, pc_target, flush, retired
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: selects writeback data, drives a registered register-file
// write port, resolves branch/jump, issues a one-cycle PC redirect and then
// squashes FLUSH_DEPTH younger instructions while asserting flush upstream.
//
// state  | meaning
// IDLE   | instructions presented are processed normally
// SQUASH | presented instruction is dropped; cnt_q instructions left to kill
module wb_stage #(
    parameter int DATA_W      = 33,
    parameter int REG_AW      = 6,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    wb_stage_if.slave bus
);
    // FLUSH_DEPTH=0 still needs a legal (unused) one-bit counter
    localparam int CNT_W = (FLUSH_DEPTH > 0) ? $clog2(FLUSH_DEPTH + 1) : 1;

    typedef enum logic {IDLE, SQUASH} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rf_we_q;
    logic [REG_AW-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic              pc_redirect_q;
    logic [DATA_W-1:0] pc_target_q;
    logic              flush_q;
    logic [31:0]       retired_q;

    logic              live;
    logic              taken;
    logic [DATA_W-1:0] wdata_sel;
    logic [DATA_W-1:0] target_sel;

    assign live = (state_q == IDLE) &&
                  (bus.in_ctrl_regwrt || bus.in_ctrl_branch || bus.in_ctrl_jump);

    // jump wins over branch; btype picks the branch condition flag
    assign taken = bus.in_ctrl_jump ||
                   (bus.in_ctrl_branch &&
                    (bus.in_ctrl_btype ? bus.in_ctrl_neg : bus.in_ctrl_zero));

    assign wdata_sel  = bus.in_ctrl_memtoreg ? bus.in_memdata : bus.in_aluresult;
    // jumps are memory-indirect, branches use the ALU-computed target
    assign target_sel = bus.in_ctrl_jump ? bus.in_memdata : bus.in_aluresult;

    // Squash FSM together with all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            pc_redirect_q <= 1'b0;
            pc_target_q   <= '0;
            flush_q       <= 1'b0;
            retired_q     <= '0;
        end else begin
            rf_we_q       <= live && bus.in_ctrl_regwrt;
            pc_redirect_q <= live && taken;

            if (live && bus.in_ctrl_regwrt) begin
                rf_waddr_q <= bus.in_rd;
                rf_wdata_q <= wdata_sel;
            end

            if (live && taken) begin
                pc_target_q <= target_sel;
            end

            if (live) begin
                retired_q <= retired_q + 32'd1;
            end

            unique case (state_q)
                IDLE: begin
                    if ((FLUSH_DEPTH > 0) && live && taken) begin
                        state_q <= SQUASH;
                        cnt_q   <= CNT_W'(FLUSH_DEPTH);
                        flush_q <= 1'b1;
                    end
                end
                SQUASH: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rf_we       = rf_we_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.pc_redirect = pc_redirect_q;
    assign bus.pc_target   = pc_target_q;
    assign bus.flush       = flush_q;
    assign bus.retired     = retired_q;
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the pipelined datapath, placed directly downstream of the EX/WB pipeline buffer and consuming its outputs. Each cycle it selects the writeback value (memory data or ALU result), drives a registered register-file write port, resolves branch/jump outcome from the buffered condition flags, and issues a one-cycle PC redirect. After a taken control transfer it runs a squash window that kills the younger instructions already in flight and drives a flush signal to upstream stages. A retired-instruction counter is included for debug.

## Interface
- DATA_W, 33, width of data, ALU result and PC target paths
- REG_AW, 6, register-file address width
- FLUSH_DEPTH, 2, number of younger instructions squashed after a taken branch/jump (0 allowed)
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_ctrl_regwrt, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump, in_ctrl_memtoreg, in_ctrl_neg, in_ctrl_zero  input  1 each  control/flags from EX/WB buffer
- in_memdata  input  DATA_W  memory read data
- in_aluresult  input  DATA_W  ALU result
- in_rd  input  REG_AW  destination register
- rf_we  output  1  register-file write enable
- rf_waddr  output  REG_AW  write address
- rf_wdata  output  DATA_W  write data
- pc_redirect  output  1  one-cycle pulse: load pc_target into PC
- pc_target  output  DATA_W  redirect target
- flush  output  1  high while squash window active; upstream converts to bubbles
- retired  output  32  count of non-squashed, non-bubble instructions

## Operation
- Instruction "live" in a cycle when FSM is IDLE and at least one of regwrt/branch/jump is 1; otherwise bubble or squashed.
- Write data: memtoreg=1 -> in_memdata, else in_aluresult.
- Taken: jump=1, or branch=1 and (btype=0 ? zero : neg). jump has priority over branch when both set.
- Target: jump -> in_memdata (memory-indirect jump); branch -> in_aluresult.
- Live instruction with regwrt=1: rf_we/rf_waddr/rf_wdata registered from it. A taken branch/jump with regwrt=1 still performs its write.
- Live taken instruction: pc_redirect/pc_target registered; if FLUSH_DEPTH>0, FSM enters SQUASH with counter=FLUSH_DEPTH.
- FSM states: IDLE, SQUASH. SQUASH: each cycle the presented instruction is dropped (no write, no redirect, no retire count), counter decrements; counter reaching 1 on a cycle -> IDLE next cycle. Taken branches arriving during SQUASH are ignored.
- Counter width clog2(FLUSH_DEPTH+1); FLUSH_DEPTH=0: FSM never leaves IDLE, flush constant 0.
- retired increments by 1 per live instruction, wraps 0xFFFFFFFF -> 0.

## Timing
- Reset (async assert, sync release): rf_we=0, rf_waddr=0, rf_wdata=0, pc_redirect=0, pc_target=0, flush=0, retired=0, FSM=IDLE. Reset mid-SQUASH aborts squash immediately.
- Inputs sampled at rising edge ending cycle t; rf_* and pc_* visible in cycle t+1 (latency 1). rf_we and pc_redirect high exactly one cycle per instruction; rf_waddr/rf_wdata/pc_target hold last value when not enabled.
- Taken at t: pc_redirect high in t+1; flush high in cycles t+1 .. t+FLUSH_DEPTH; instructions presented in those cycles squashed; instruction at t+FLUSH_DEPTH+1 processed normally.
- Back-to-back taken branches: only the first acts; the second (inside window) is squashed.
- retired updates at same edge as rf_we (visible t+1).

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0; release -> still 0 until first live instruction.
- ALU write: regwrt=1, memtoreg=0, aluresult=0x0_0000_1234, rd=5 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, retired=1; memtoreg=1, memdata=0xABCD, rd=7 -> rf_wdata=0xABCD, rf_waddr=7.
- Branch conditions: branch=1, btype=0, zero=1, aluresult=0x40 -> pc_redirect=1, pc_target=0x40, flush high 2 cycles; btype=1, neg=0 -> no redirect, flush stays 0, retired still increments.
- Squash: jump=1, memdata=0x80 at t, regwrt=1 rd=3 at t+1 and t+2, regwrt=1 rd=4 at t+3 -> redirect 0x80 at t+1, no writes for rd=3, rf_we for rd=4 at t+4, retired +2.
- Back-to-back taken: jump at t and t+1 -> single redirect pulse at t+1, flush only t+1..t+2.
- Reset mid-squash: deassert rst_n during flush=1 -> flush=0 immediately; after release, next live instruction writes normally.
